cart_load_ctrl: RTL and testbench

Sequencer between the HPS download stream and the 8 KB cartridge dual-port RAM. It accepts ROM bytes for the cartridge slot, writes them into the RAM write port, and tracks the loaded image size for the bank-switch logic. When the `CART_FILL_EN` macro is defined, it also scrubs unused RAM after a load. It holds the console core in reset until the image is complete and stable, then releases it and flags the cartridge as valid.

---
 rtl/cart_load_ctrl.sv | 150 +++++++++++++++
 tb/tb_cart_load_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_load_ctrl.sv
// Cartridge ROM load sequencer: streams HPS download bytes into the 8 KB cart RAM,
// tracks image size, and holds the console core in reset until the image is stable.
// Optional post-load scrub of unused RAM is enabled with `define CART_FILL_EN.
module cart_load_ctrl #(
    parameter int unsigned ROM_INDEX   = 1,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [12:0] ram_addr,
    output logic [7:0]  ram_data,
    output logic        ram_we,
    output logic [13:0] cart_size,
    output logic        overflow,
    output logic        core_reset,
    output logic        cart_valid
);

    typedef enum logic [2:0] {IDLE, LOAD, FILL, HOLD, RUN} state_t;

    state_t      state;
    logic [7:0]  hold_cnt;
    logic        idx_match;
    logic        sel;
    logic        start;
    logic        take;
    logic        in_range;
    logic [13:0] addr_next;
    logic [13:0] base_size;
    logic [13:0] size_next;
    logic [9:0]  unused_bits;

    assign idx_match = (ioctl_index[5:0] == 6'(ROM_INDEX));
    assign sel       = ioctl_download & idx_match;
    assign start     = sel && (state == IDLE || state == RUN || state == FILL);
    // A strobe in the cycle sel drops (still in LOAD) or in the cycle a load starts is kept.
    assign take      = ioctl_wr && idx_match && (state == LOAD || start);
    assign in_range  = (ioctl_addr[24:13] == 12'd0);
    assign addr_next = {1'b0, ioctl_addr[12:0]} + 14'd1;
    assign base_size = start ? 14'd0 : cart_size;
    assign size_next = (take && in_range && addr_next > base_size) ? addr_next : base_size;

    assign unused_bits = {ioctl_index[7:6], FILL_BYTE};

`ifdef CART_FILL_EN
    logic [13:0] fill_ptr;

    assign ioctl_wait = (state == FILL) && sel;
`else
    assign ioctl_wait = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ram_we     <= 1'b0;
            ram_addr   <= 13'd0;
            ram_data   <= 8'd0;
            cart_size  <= 14'd0;
            overflow   <= 1'b0;
            cart_valid <= 1'b0;
            core_reset <= 1'b1;
            hold_cnt   <= 8'd0;
`ifdef CART_FILL_EN
            fill_ptr   <= 14'd0;
`endif
        end else begin
            ram_we    <= 1'b0;
            cart_size <= size_next;
            if (take && in_range) begin
                ram_we   <= 1'b1;
                ram_addr <= ioctl_addr[12:0];
                ram_data <= ioctl_dout;
            end
            if (take && !in_range)
                overflow <= 1'b1;
            else if (start)
                overflow <= 1'b0;

            case (state)
                IDLE, RUN: begin
                    if (start) begin
                        state      <= LOAD;
                        cart_valid <= 1'b0;
                        core_reset <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!sel) begin
`ifdef CART_FILL_EN
                        if (size_next != 14'd8192) begin
                            state <= FILL;
                            // The first fill write shares this edge unless a final byte owns the port.
                            if (take && in_range) begin
                                fill_ptr <= size_next;
                            end else begin
                                ram_we   <= 1'b1;
                                ram_addr <= size_next[12:0];
                                ram_data <= FILL_BYTE;
                                fill_ptr <= size_next + 14'd1;
                            end
                        end else begin
                            state    <= HOLD;
                            hold_cnt <= 8'd0;
                        end
`else
                        state    <= HOLD;
                        hold_cnt <= 8'd0;
`endif
                    end
                end
                FILL: begin
`ifdef CART_FILL_EN
                    if (start) begin
                        state <= LOAD;
                    end else if (fill_ptr == 14'd8192) begin
                        state    <= HOLD;
                        hold_cnt <= 8'd0;
                    end else begin
                        ram_we   <= 1'b1;
                        ram_addr <= fill_ptr[12:0];
                        ram_data <= FILL_BYTE;
                        fill_ptr <= fill_ptr + 14'd1;
                    end
`else
                    state <= IDLE;
`endif
                end
                HOLD: begin
                    if (hold_cnt == 8'(HOLD_CYCLES - 1)) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                        cart_valid <= (cart_size != 14'd0);
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cart_load_ctrl.sv
// Directed bench for cart_load_ctrl: load timing, overflow, index filtering,
// reset recovery and (with CART_FILL_EN) RAM scrub and fill abort.
module tb_cart_load_ctrl;

    localparam int H = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [12:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_we;
    logic [13:0] cart_size;
    logic        overflow;
    logic        core_reset;
    logic        cart_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cart_load_ctrl #(.ROM_INDEX(1), .HOLD_CYCLES(H), .FILL_BYTE(8'hFF)) dut (
        .clk(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_we(ram_we), .cart_size(cart_size), .overflow(overflow),
        .core_reset(core_reset), .cart_valid(cart_valid)
    );

    function automatic logic [7:0] pat(input int a);
        logic [31:0] v;
        v = a;
        return v[7:0] ^ {v[12:8], 3'b101};
    endfunction

    // Stream n consecutive bytes at index 1; leaves download high, wr low.
    task automatic load_bytes(input int n, output int seen, output int bad);
        seen = 0;
        bad  = 0;
        @(negedge clk);
        ioctl_download = 1'b1;
        ioctl_index    = 8'd1;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (ram_we) begin
                seen++;
                if (ram_addr !== 13'(i - 1) || ram_data !== pat(i - 1)) bad++;
            end
            if (i < n) begin
                ioctl_wr   = 1'b1;
                ioctl_addr = 25'(i);
                ioctl_dout = pat(i);
            end else begin
                ioctl_wr = 1'b0;
            end
        end
    endtask

    // Count negedges until core_reset drops, tallying fill writes along the way.
    task automatic measure_release(input int fill_from, output int cycles,
                                   output int fills, output int fill_bad);
        cycles   = -1;
        fills    = 0;
        fill_bad = 0;
        for (int k = 1; k <= 20000; k++) begin
            @(negedge clk);
            if (ram_we) begin
                fills++;
                if (ram_addr !== 13'(fill_from + fills - 1) || ram_data !== 8'hFF) fill_bad++;
            end
            if (!core_reset) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks += 8;
        if (ram_we !== 1'b0)      begin n_fail++; $display("FAIL reset_ram_we got %b exp 0", ram_we); end
        if (ioctl_wait !== 1'b0)  begin n_fail++; $display("FAIL reset_wait got %b exp 0", ioctl_wait); end
        if (overflow !== 1'b0)    begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        if (cart_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid got %b exp 0", cart_valid); end
        if (cart_size !== 14'd0)  begin n_fail++; $display("FAIL reset_size got %0d exp 0", cart_size); end
        if (ram_addr !== 13'd0)   begin n_fail++; $display("FAIL reset_addr got %0d exp 0", ram_addr); end
        if (ram_data !== 8'd0)    begin n_fail++; $display("FAIL reset_data got %h exp 00", ram_data); end
        if (core_reset !== 1'b1)  begin n_fail++; $display("FAIL reset_core got %b exp 1", core_reset); end
    endtask

    task automatic test_load_4096;
        int seen, bad, cyc, fills, fbad, exp_cyc, exp_fills;
        load_bytes(4096, seen, bad);
        n_checks += 5;
        if (seen !== 4096) begin n_fail++; $display("FAIL load4k_pulses got %0d exp 4096", seen); end
        if (bad !== 0)     begin n_fail++; $display("FAIL load4k_addr_data bad %0d exp 0", bad); end
        if (cart_size !== 14'd4096) begin n_fail++; $display("FAIL load4k_size got %0d exp 4096", cart_size); end
        if (ioctl_wait !== 1'b0) begin n_fail++; $display("FAIL load4k_wait got %b exp 0", ioctl_wait); end
        if (core_reset !== 1'b1) begin n_fail++; $display("FAIL load4k_held got %b exp 1", core_reset); end
        ioctl_download = 1'b0;
`ifdef CART_FILL_EN
        exp_cyc = 1 + H + 4096; exp_fills = 4096;
`else
        exp_cyc = 1 + H; exp_fills = 0;
`endif
        measure_release(4096, cyc, fills, fbad);
        n_checks += 4;
        if (cyc !== exp_cyc)     begin n_fail++; $display("FAIL load4k_release got %0d exp %0d", cyc, exp_cyc); end
        if (fills !== exp_fills) begin n_fail++; $display("FAIL load4k_fills got %0d exp %0d", fills, exp_fills); end
        if (fbad !== 0)          begin n_fail++; $display("FAIL load4k_fill_data bad %0d exp 0", fbad); end
        if (cart_valid !== 1'b1) begin n_fail++; $display("FAIL load4k_valid got %b exp 1", cart_valid); end
    endtask

    task automatic test_other_index;
        int writes, held;
        writes = 0;
        held   = 0;
        @(negedge clk);
        ioctl_download = 1'b1;
        ioctl_index    = 8'd2;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ram_we) writes++;
            if (core_reset) held++;
            ioctl_wr   = (i < 10);
            ioctl_addr = 25'(i);
            ioctl_dout = 8'h33;
        end
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        @(negedge clk);
        n_checks += 4;
        if (writes !== 0) begin n_fail++; $display("FAIL idx2_writes got %0d exp 0", writes); end
        if (held !== 0)   begin n_fail++; $display("FAIL idx2_core_reset high %0d cycles exp 0", held); end
        if (cart_size !== 14'd4096) begin n_fail++; $display("FAIL idx2_size got %0d exp 4096", cart_size); end
        if (cart_valid !== 1'b1) begin n_fail++; $display("FAIL idx2_valid got %b exp 1", cart_valid); end
    endtask

    task automatic test_overflow;
        int seen, bad, cyc, fills, fbad;
        load_bytes(100, seen, bad);
        n_checks += 3;
        if (seen !== 100 || bad !== 0) begin n_fail++; $display("FAIL ovf_load seen %0d bad %0d exp 100/0", seen, bad); end
        if (cart_size !== 14'd100) begin n_fail++; $display("FAIL ovf_size_pre got %0d exp 100", cart_size); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pre got %b exp 0", overflow); end
        ioctl_wr = 1'b1; ioctl_addr = 25'd8192; ioctl_dout = 8'hAA;
        @(negedge clk);
        n_checks += 3;
        if (ram_we !== 1'b0)   begin n_fail++; $display("FAIL ovf_we got %b exp 0", ram_we); end
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        if (cart_size !== 14'd100) begin n_fail++; $display("FAIL ovf_size got %0d exp 100", cart_size); end
        // Final byte arrives in the same cycle the download window closes.
        ioctl_wr = 1'b1; ioctl_addr = 25'd100; ioctl_dout = pat(100);
        ioctl_download = 1'b0;
        @(negedge clk);
        ioctl_wr = 1'b0;
        n_checks += 3;
        if (ram_we !== 1'b1 || ram_addr !== 13'd100 || ram_data !== pat(100))
            begin n_fail++; $display("FAIL ovf_last_byte we %b addr %0d data %h exp 1/100/%h", ram_we, ram_addr, ram_data, pat(100)); end
        if (cart_size !== 14'd101) begin n_fail++; $display("FAIL ovf_size_last got %0d exp 101", cart_size); end
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
        measure_release(101, cyc, fills, fbad);
        n_checks += 3;
`ifdef CART_FILL_EN
        if (cyc <= 0 || fills !== 8091 || fbad !== 0)
            begin n_fail++; $display("FAIL ovf_fill cyc %0d fills %0d bad %0d exp >0/8091/0", cyc, fills, fbad); end
`else
        if (cyc !== H || fills !== 0)
            begin n_fail++; $display("FAIL ovf_release cyc %0d fills %0d exp %0d/0", cyc, fills, H); end
`endif
        if (cart_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid got %b exp 1", cart_valid); end
        if (overflow !== 1'b1)   begin n_fail++; $display("FAIL ovf_run_flag got %b exp 1", overflow); end
    endtask

    task automatic test_empty;
        int seen, bad, cyc, fills, fbad, exp_cyc, exp_fills;
        load_bytes(0, seen, bad);
        n_checks += 3;
        if (seen !== 0) begin n_fail++; $display("FAIL empty_writes got %0d exp 0", seen); end
        if (cart_size !== 14'd0) begin n_fail++; $display("FAIL empty_size got %0d exp 0", cart_size); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL empty_ovf_clear got %b exp 0", overflow); end
        ioctl_download = 1'b0;
`ifdef CART_FILL_EN
        exp_cyc = 1 + H + 8192; exp_fills = 8192;
`else
        exp_cyc = 1 + H; exp_fills = 0;
`endif
        measure_release(0, cyc, fills, fbad);
        n_checks += 3;
        if (cyc !== exp_cyc) begin n_fail++; $display("FAIL empty_release got %0d exp %0d", cyc, exp_cyc); end
        if (fills !== exp_fills || fbad !== 0) begin n_fail++; $display("FAIL empty_fills got %0d bad %0d exp %0d/0", fills, fbad, exp_fills); end
        if (cart_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid got %b exp 0", cart_valid); end
    endtask

    task automatic test_reset_mid_load;
        int seen, bad, cyc, fills, fbad;
        load_bytes(100, seen, bad);
        reset = 1'b1;
        #1;
        n_checks += 4;
        if (core_reset !== 1'b1) begin n_fail++; $display("FAIL midrst_core got %b exp 1", core_reset); end
        if (ram_we !== 1'b0)     begin n_fail++; $display("FAIL midrst_we got %b exp 0", ram_we); end
        if (cart_size !== 14'd0) begin n_fail++; $display("FAIL midrst_size got %0d exp 0", cart_size); end
        if (cart_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b exp 0", cart_valid); end
        ioctl_download = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        load_bytes(8192, seen, bad);
        n_checks += 2;
        if (seen !== 8192 || bad !== 0) begin n_fail++; $display("FAIL full_load seen %0d bad %0d exp 8192/0", seen, bad); end
        if (cart_size !== 14'd8192) begin n_fail++; $display("FAIL full_size got %0d exp 8192", cart_size); end
        ioctl_download = 1'b0;
        measure_release(8192, cyc, fills, fbad);
        n_checks += 2;
        if (cyc !== 1 + H || fills !== 0) begin n_fail++; $display("FAIL full_release cyc %0d fills %0d exp %0d/0", cyc, fills, 1 + H); end
        if (cart_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid got %b exp 1", cart_valid); end
    endtask

`ifdef CART_FILL_EN
    task automatic test_fill_2048;
        int seen, bad, cyc, fills, fbad;
        load_bytes(2048, seen, bad);
        ioctl_download = 1'b0;
        measure_release(2048, cyc, fills, fbad);
        n_checks += 3;
        if (fills !== 6144) begin n_fail++; $display("FAIL fill2k_count got %0d exp 6144", fills); end
        if (fbad !== 0)     begin n_fail++; $display("FAIL fill2k_data bad %0d exp 0", fbad); end
        if (cyc !== 1 + H + 6144) begin n_fail++; $display("FAIL fill2k_release got %0d exp %0d", cyc, 1 + H + 6144); end
    endtask

    task automatic test_fill_abort;
        int seen, bad, cyc, fills, fbad;
        load_bytes(2048, seen, bad);
        ioctl_download = 1'b0;
        repeat (10) @(negedge clk);
        ioctl_download = 1'b1;
        ioctl_index    = 8'd1;
        #1;
        n_checks += 1;
        if (ioctl_wait !== 1'b1) begin n_fail++; $display("FAIL abort_wait_hi got %b exp 1", ioctl_wait); end
        @(negedge clk);
        n_checks += 3;
        if (ioctl_wait !== 1'b0) begin n_fail++; $display("FAIL abort_wait_lo got %b exp 0", ioctl_wait); end
        if (ram_we !== 1'b0)     begin n_fail++; $display("FAIL abort_we got %b exp 0", ram_we); end
        if (cart_size !== 14'd0) begin n_fail++; $display("FAIL abort_size got %0d exp 0", cart_size); end
        ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = pat(0);
        @(negedge clk);
        ioctl_wr = 1'b0;
        n_checks += 2;
        if (ram_we !== 1'b1 || ram_addr !== 13'd0 || ram_data !== pat(0))
            begin n_fail++; $display("FAIL abort_first we %b addr %0d data %h exp 1/0/%h", ram_we, ram_addr, ram_data, pat(0)); end
        if (cart_size !== 14'd1) begin n_fail++; $display("FAIL abort_size1 got %0d exp 1", cart_size); end
        @(negedge clk);
        ioctl_download = 1'b0;
        measure_release(1, cyc, fills, fbad);
        n_checks += 1;
        if (cyc !== 1 + H + 8191 || fills !== 8191 || fbad !== 0)
            begin n_fail++; $display("FAIL abort_release cyc %0d fills %0d bad %0d exp %0d/8191/0", cyc, fills, fbad, 1 + H + 8191); end
    endtask
`endif

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'd0;
        repeat (3) @(posedge clk);
        test_reset;
        @(negedge clk);
        reset = 1'b0;
        test_load_4096;
        test_other_index;
        test_overflow;
        test_empty;
        test_reset_mid_load;
`ifdef CART_FILL_EN
        test_fill_2048;
        test_fill_abort;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
